tpu_requant: RTL and testbench
==============================

# tpu_requant

Output stage that sits directly downstream of the TPU C buffer. It consumes 128-bit C rows, each holding four int32 accumulator lanes with lane 0 in bits [127:96], and applies TFLite-style requantization to each lane: bias add, fixed-point multiply, rounding right shift, output offset and activation clamp. It returns one 32-bit word of four packed int8 values per row to the CFU response path. It is a 3-stage valid/ready pipeline with per-lane configuration registers.

## Interface
- Parameters:
  - LANES, 4, accumulator lanes per C row; fixed at 4, other values unsupported.
  - ACC_W, 32, accumulator lane width.
- Ports:
  - clk  in  1  clock.
  - rst_n  in  1  reset; synchronous, active-low.
  - cfg_we  in  1  configuration write strobe.
  - cfg_addr  in  4  register select: 0-3 bias[lane]; 4-7 mult[lane]; 8-11 shift[lane]; 12 out_offset; 13 act range.
  - cfg_data  in  32  write data. Shift uses [4:0]. out_offset uses [15:0] signed. Act range is {act_max[15:8], act_min[7:0]} as int8.
  - in_valid  in  1  C row available.
  - in_ready  out  1  row accepted when in_valid && in_ready.
  - in_data  in  128  C row, lane k at bits [127-32k -: 32], signed.
  - out_valid  out  1  packed result available.
  - out_ready  in  1  consumer accepts result.
  - out_data  out  32  lane k int8 at bits [31-8k -: 8].
  - busy  out  1  any pipeline stage holds valid data.
  - row_count  out  16  rows emitted since reset; wraps at 0xFFFF→0.
  - cfg_err  out  1  sticky; set by a config write while busy.

## Operation
- Config writes are accepted only when busy=0.
  - A write while busy=1 is dropped and sets cfg_err; cfg_err clears only on reset.
  - Addresses 14-15 are ignored.
- Reset values of config registers: bias=0, mult=0, shift=0, out_offset=0, act_min=-128, act_max=127.
- Per lane, signed arithmetic:
  - S1: x = acc + bias, 32-bit wrap.
  - S2: p = x × mult as a 64-bit product; y = (p + 2^30) >>> 31. If x = mult = INT32_MIN, then y = 0x7FFFFFFF.
  - S3 rounding shift, with s = shift:
    - mask = 2^s−1; rem = y & mask; thr = (mask>>1) + (y<0).
    - z = (y >>> s) + (rem > thr).
  - S3 output: w = z + out_offset computed at 33 bits; clamp to [act_min, act_max]; keep the low 8 bits.
- If act_min > act_max, the result is act_max.
- Output lane order matches input lane order.

## Timing
- Advance enable: adv = !s3_valid || out_ready.
- in_ready = adv, combinational.
- All stages shift together on adv. When adv=0 all stages hold, and in_data is not sampled.
- Latency: a row accepted at edge N presents out_valid at edge N+3 when there is no stall.
- Full throughput: 1 row/cycle with out_ready held high.
- out_data is stable while out_valid && !out_ready.
- row_count increments on each out_valid && out_ready.
- Reset mid-operation: all valids and row_count clear at the next edge, in-flight rows are discarded, and config returns to reset values.
- Reset values of outputs: out_valid=0, out_data=0, busy=0, row_count=0, cfg_err=0; in_ready=1 after reset.
- cfg_we and an in_valid handshake in the same cycle when busy=0: the write is applied, and the incoming row uses the new values from S1 onward. The pipeline is empty, so no row uses a mix of old and new values.

## Configuration
- PER_CHANNEL_QUANT_EN defined:
  - Four independent bias, mult and shift registers, one per lane.
- PER_CHANNEL_QUANT_EN undefined:
  - Only lane 0 registers exist (addresses 0, 4, 8). Writes to 1-3, 5-7 and 9-11 are ignored.
  - All lanes use the lane 0 values.
- bias is per-lane in both builds when the macro is defined. It is shared under the same rule when undefined.

## Structure
- Shared package tpu_pkg:
  - Constants ACC_W, LANES, INT8_MIN/MAX.
  - Config address localparams.
  - Struct type for the per-lane quant parameters {bias, mult, shift}.
- One sub-module, requant_lane: the per-lane S1-S3 datapath with external stage enables. Instantiated 4× by a generate loop.
- The top level holds the config registers, the valid/ready pipeline control, row_count, cfg_err and packing.

## Test plan
- Identity, mult=0x7FFFFFFF, shift=0, offset=0, input lanes {5,−5,127,−200}: out_data=0x05FB7F80, latency 3 cycles.
- Half-scale, mult=0x40000000, offset=−128, lane0=100: lane0 byte=0xB2 (−78).
- Rounding, mult=0x7FFFFFFF, shift=1, lanes {5,−5,3,−3}: bytes {3,−3,2,−2} = 0x03FD02FE.
- Saturation, bias=0, mult=0x80000000, lane=0x80000000: lane byte=0x7F. With act range 0x1000, the byte becomes 0x10.
- Backpressure: stream 5 rows, out_ready low for cycles 4-7:
  - no row is lost or duplicated;
  - out_data holds during the stall;
  - row_count ends at 5.
- Config while busy: cfg_we with one row in flight → write is ignored and cfg_err=1. Then reset → cfg_err=0 and all outputs at their reset values.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared constants and types for the TPU requantization output stage.
package tpu_pkg;
  localparam int ACC_W  = 32;
  localparam int LANES  = 4;
  localparam int STAGES = 3;  // S1..S3 after the input capture register

  localparam logic signed [7:0] INT8_MIN = -8'sd128;
  localparam logic signed [7:0] INT8_MAX = 8'sd127;

  localparam logic [3:0] CFG_BIAS   = 4'd0;
  localparam logic [3:0] CFG_MULT   = 4'd4;
  localparam logic [3:0] CFG_SHIFT  = 4'd8;
  localparam logic [3:0] CFG_OFFSET = 4'd12;
  localparam logic [3:0] CFG_ACT    = 4'd13;

  typedef struct packed {
    logic [ACC_W-1:0] bias;
    logic [ACC_W-1:0] mult;
    logic [4:0]       shift;
  } quant_t;
endpackage

// File: rtl/tpu_requant_lane.sv
// One accumulator lane: capture, bias add, doubling high multiply, rounding shift, offset and clamp.
module requant_lane
  import tpu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [STAGES:0]  en,
  input  logic [ACC_W-1:0] acc_i,
  input  logic [ACC_W-1:0] bias_i,
  input  logic [ACC_W-1:0] mult_i,
  input  logic [4:0]       shift_i,
  input  logic [15:0]      offset_i,
  input  logic [7:0]       act_min_i,
  input  logic [7:0]       act_max_i,
  output logic [7:0]       res_o
);
  logic [ACC_W-1:0] acc_q, x_q, x_d, y_q, y_d;
  logic [7:0]       res_q, res_d;
  logic signed [2*ACC_W-1:0] prod;
  logic [ACC_W-1:0] mask, rem, thr, z;
  logic signed [ACC_W:0] w, lo, hi, r;

  always_comb begin
    x_d  = acc_q + bias_i;

    prod = 64'($signed(x_q)) * 64'($signed(mult_i));
    // INT32_MIN squared is the only product whose rounded high half overflows
    if (x_q == 32'h8000_0000 && mult_i == 32'h8000_0000) y_d = 32'h7FFF_FFFF;
    else y_d = ACC_W'((prod + 64'sh4000_0000) >>> 31);

    mask = (32'd1 << shift_i) - 32'd1;
    rem  = y_q & mask;
    thr  = (mask >> 1) + 32'(y_q[ACC_W-1]);
    z    = 32'($signed(y_q) >>> shift_i) + 32'(rem > thr);

    w  = 33'($signed(z)) + 33'($signed(offset_i));
    lo = 33'($signed(act_min_i));
    hi = 33'($signed(act_max_i));
    // Upper bound applied last so an inverted range collapses to act_max
    r = (w < lo) ? lo : w;
    if (r > hi) r = hi;
    res_d = 8'(r);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      res_q <= '0;
    end else begin
      if (en[0]) acc_q <= acc_i;
      if (en[1]) x_q   <= x_d;
      if (en[2]) y_q   <= y_d;
      if (en[3]) res_q <= res_d;
    end
  end

  assign res_o = res_q;
endmodule

// File: rtl/tpu_requant.sv
// TPU C-row requantization stage: config registers, valid/ready pipeline, int8 packing.
// Define PER_CHANNEL_QUANT_EN for per-lane bias/mult/shift; otherwise lane 0 values are shared.
module tpu_requant #(
  parameter int LANES = 4,
  parameter int ACC_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [3:0]             cfg_addr,
  input  logic [31:0]            cfg_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*ACC_W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*8-1:0]     out_data,
  output logic                   busy,
  output logic [15:0]            row_count,
  output logic                   cfg_err
);
  import tpu_pkg::*;

`ifdef PER_CHANNEL_QUANT_EN
  localparam int NPRM = LANES;
`else
  localparam int NPRM = 1;
`endif

  quant_t          prm_q [NPRM];
  quant_t          prm_d [NPRM];
  logic [15:0]     off_q, off_d;
  logic [7:0]      amin_q, amin_d, amax_q, amax_d;
  logic [STAGES:0] vld_pipe_q, vld_pipe_d;
  logic [15:0]     row_count_q, row_count_d;
  logic            cfg_err_q, cfg_err_d;
  logic            adv, cfg_ok;
  logic [STAGES:0] lane_en;

  assign adv       = !vld_pipe_q[STAGES] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[STAGES];
  assign busy      = |vld_pipe_q;
  assign row_count = row_count_q;
  assign cfg_err   = cfg_err_q;
  assign cfg_ok    = cfg_we && !busy;
  // A stage only loads when the slot feeding it holds a row
  assign lane_en   = {(STAGES+1){adv}} & {vld_pipe_q[STAGES-1:0], in_valid};

  always_comb begin
    prm_d     = prm_q;
    off_d     = off_q;
    amin_d    = amin_q;
    amax_d    = amax_q;
    cfg_err_d = cfg_err_q | (cfg_we & busy);
    if (cfg_ok) begin
      for (int j = 0; j < NPRM; j++) begin
        if (cfg_addr[1:0] == 2'(j)) begin
          case (cfg_addr[3:2])
            CFG_BIAS[3:2]:  prm_d[j].bias  = cfg_data;
            CFG_MULT[3:2]:  prm_d[j].mult  = cfg_data;
            CFG_SHIFT[3:2]: prm_d[j].shift = cfg_data[4:0];
            default: ;
          endcase
        end
      end
      if (cfg_addr == CFG_OFFSET) off_d = cfg_data[15:0];
      if (cfg_addr == CFG_ACT) {amax_d, amin_d} = cfg_data[15:0];
    end
  end

  always_comb begin
    vld_pipe_d  = vld_pipe_q;
    if (adv) vld_pipe_d = {vld_pipe_q[STAGES-1:0], in_valid};
    row_count_d = row_count_q + 16'(out_valid && out_ready);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int j = 0; j < NPRM; j++) prm_q[j] <= '0;
      off_q       <= '0;
      amin_q      <= INT8_MIN;
      amax_q      <= INT8_MAX;
      vld_pipe_q  <= '0;
      row_count_q <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      prm_q       <= prm_d;
      off_q       <= off_d;
      amin_q      <= amin_d;
      amax_q      <= amax_d;
      vld_pipe_q  <= vld_pipe_d;
      row_count_q <= row_count_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    localparam int PI = (NPRM == 1) ? 0 : k;
    requant_lane u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (lane_en),
      .acc_i     (in_data[(LANES-1-k)*ACC_W +: ACC_W]),
      .bias_i    (prm_q[PI].bias),
      .mult_i    (prm_q[PI].mult),
      .shift_i   (prm_q[PI].shift),
      .offset_i  (off_q),
      .act_min_i (amin_q),
      .act_max_i (amax_q),
      .res_o     (out_data[(LANES-1-k)*8 +: 8])
    );
  end
endmodule

// File: tb/tb_tpu_requant.sv
// Randomized self-checking bench for tpu_requant against a behavioural requantization model.
module tb_tpu_requant;
  logic         clk = 1'b0, rst_n = 1'b0, cfg_we = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]   cfg_addr = '0;
  logic [31:0]  cfg_data = '0;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, busy, cfg_err;
  logic [31:0]  out_data;
  logic [15:0]  row_count;

  tpu_requant dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .row_count(row_count), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  localparam int IMIN = -2147483647 - 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Behavioural model state
  int m_bias[4], m_mult[4], m_shift[4], m_off, m_amin, m_amax;
  logic [31:0] exp_q[$];
  int n_out = 0;
  logic [31:0] last_out = '0;
  bit rdy_rand = 0;

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin m_bias[k] = 0; m_mult[k] = 0; m_shift[k] = 0; end
    m_off = 0; m_amin = -128; m_amax = 127;
  endfunction

  function automatic void model_cfg(input logic [3:0] a, input logic [31:0] d);
    int lane;
    lane = int'(a[1:0]);
    for (int k = 0; k < 4; k++) begin
`ifdef PER_CHANNEL_QUANT_EN
      if (k != lane) continue;
`else
      if (lane != 0) continue;
`endif
      case (a[3:2])
        2'd0: m_bias[k]  = int'(d);
        2'd1: m_mult[k]  = int'(d);
        2'd2: m_shift[k] = int'(d[4:0]);
        default: ;
      endcase
    end
    if (a == 4'd12) m_off = int'($signed(d[15:0]));
    if (a == 4'd13) begin m_amin = int'($signed(d[7:0])); m_amax = int'($signed(d[15:8])); end
  endfunction

  // Round-to-nearest with ties away from zero, then offset and clamp
  function automatic logic [7:0] ref_lane(input int k, input logic [31:0] acc);
    int x;
    longint y, a, q, z, w;
    x = int'(acc) + m_bias[k];
    if (x == IMIN && m_mult[k] == IMIN) y = 64'sd2147483647;
    else y = (longint'(x) * longint'(m_mult[k]) + 64'sd1073741824) >>> 31;
    a = (y < 0) ? -y : y;
    q = (m_shift[k] == 0) ? a : ((a + (64'sd1 <<< (m_shift[k] - 1))) >>> m_shift[k]);
    z = (y < 0) ? -q : q;
    w = z + longint'(m_off);
    if (m_amin > m_amax) w = m_amax;
    else if (w < m_amin) w = m_amin;
    else if (w > m_amax) w = m_amax;
    return w[7:0];
  endfunction

  function automatic logic [31:0] model_row(input logic [127:0] d);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[31-8*k -: 8] = ref_lane(k, d[127-32*k -: 32]);
    return r;
  endfunction

  function automatic logic [127:0] pack(input int a, input int b, input int c, input int d);
    return {a, b, c, d};
  endfunction

  // Output monitor: scoreboard pop on handshake, hold check while stalled
  logic [31:0] held_d = '0;
  bit held_v = 0;
  always @(negedge clk) begin
    if (!rst_n) held_v = 0;
    else begin
      if (held_v) chk("stall_hold", out_data, held_d);
      held_v = out_valid && !out_ready;
      held_d = out_data;
      if (out_valid && out_ready) begin
        chk("rows_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) chk("row", out_data, exp_q.pop_front());
        n_out++;
        last_out = out_data;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  // All driver tasks start and end at posedge + 1
  task automatic send_row(input logic [127:0] d);
    int n = 0;
    in_valid = 1'b1; in_data = d;
    do begin @(negedge clk); n++; end while (!in_ready && n < 100);
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    else exp_q.push_back(model_row(d));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d, input bit apply = 1);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    if (apply) model_cfg(a, d);
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic cfg_lanes(input logic [3:0] base, input logic [31:0] d);
    for (int k = 0; k < 4; k++) cfg_write(base + 4'(k), d);
  endtask

  task automatic drain();
    int n = 0;
    rdy_rand = 0; out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 300) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; cfg_we = 1'b0; rdy_rand = 0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete(); n_out = 0; model_reset();
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  out_data, 32'd0);
    chk({tag, "_busy"},      32'(busy), 32'd0);
    chk({tag, "_row_count"}, 32'(row_count), 32'd0);
    chk({tag, "_cfg_err"},   32'(cfg_err), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  a;
    logic [31:0] d;
    model_reset();
    do_reset();
    chk_reset_outs("rst0");

    // Identity and latency
    cfg_lanes(4'd4, 32'h7FFF_FFFF);
    send_row(pack(5, -5, 127, -200));
    for (int i = 0; i < 3; i++) begin @(negedge clk); chk("lat_early", 32'(out_valid), 32'd0); end
    @(negedge clk);
    chk("lat_n3", 32'(out_valid), 32'd1);
    chk("identity", out_data, 32'h05FB_7F80);
    drain();
    chk("row_count_1", 32'(row_count), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);

    // Rounding shift
    cfg_lanes(4'd8, 32'd1);
    send_row(pack(5, -5, 3, -3)); drain();
    chk("rounding", last_out, 32'h03FD_02FE);

    // Half scale with negative offset
    cfg_lanes(4'd8, 32'd0);
    cfg_lanes(4'd4, 32'h4000_0000);
    cfg_write(4'd12, 32'h0000_FF80);
    send_row(pack(100, 0, 0, 0)); drain();
    chk("half_scale", last_out, 32'hB280_8080);

    // Saturation corner and narrowed activation range
    cfg_write(4'd12, 32'd0);
    cfg_lanes(4'd4, 32'h8000_0000);
    send_row(pack(IMIN, 0, 0, 0)); drain();
    chk("saturate", last_out, 32'h7F00_0000);
    cfg_write(4'd13, 32'h0000_1000);
    send_row(pack(IMIN, 0, 0, 0)); drain();
    chk("act_range", last_out, 32'h1000_0000);
    cfg_write(4'd14, 32'hFFFF_FFFF);
    cfg_write(4'd13, 32'h0000_F010);
    send_row(pack(1, 2, 3, 4)); drain();
    chk("act_inverted", last_out, 32'hF0F0_F0F0);

    // Config write in the same cycle as an accepted row
    cfg_write(4'd13, 32'h0000_7F80);
    cfg_lanes(4'd4, 32'h7FFF_FFFF);
    cfg_we = 1'b1; cfg_addr = 4'd4; cfg_data = 32'h4000_0000;
    model_cfg(4'd4, 32'h4000_0000);
    fork
      send_row(pack(100, 100, 100, 100));
      begin @(posedge clk); #1; cfg_we = 1'b0; end
    join
    drain();

    // Backpressure
    do_reset();
    cfg_lanes(4'd4, 32'h7FFF_FFFF);
    fork
      for (int i = 0; i < 5; i++) send_row(pack(i + 1, -(i + 1), 10 * i, -10 * i));
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_row_count", 32'(row_count), 32'd5);
    chk("bp_rows_out", 32'(n_out), 32'd5);

    // Config while busy is dropped and sticky
    do_reset();
    cfg_lanes(4'd4, 32'h7FFF_FFFF);
    send_row(pack(1, 2, 3, 4));
    cfg_write(4'd4, 32'h4000_0000, 0);
    chk("cfg_err_set", 32'(cfg_err), 32'd1);
    drain();
    send_row(pack(10, 20, 30, 40)); drain();
    chk("cfg_dropped", last_out, 32'h0A14_1E28);
    chk("cfg_err_sticky", 32'(cfg_err), 32'd1);

    // Reset with rows in flight
    send_row(pack(7, 7, 7, 7));
    send_row(pack(8, 8, 8, 8));
    do_reset();
    chk_reset_outs("rst_mid");
    send_row(pack(50, -50, 7, 8)); drain();
    chk("post_rst_cfg", last_out, 32'h0000_0000);
    chk("post_rst_count", 32'(row_count), 32'd1);

    // Randomized config and traffic
    for (int it = 0; it < 20; it++) begin
      drain();
      for (int c = 0; c < 3; c++) begin
        a = 4'($urandom_range(0, 15));
        case (a[3:2])
          2'd0: d = 32'(int'($urandom_range(0, 400)) - 200);
          2'd1: case ($urandom_range(0, 3))
                  0: d = 32'h7FFF_FFFF;
                  1: d = 32'h4000_0000;
                  2: d = $urandom;
                  default: d = 32'h8000_0000;
                endcase
          2'd2: d = ($urandom_range(0, 7) == 0) ? 32'd31 : 32'($urandom_range(0, 8));
          default: d = (a == 4'd12) ? 32'(int'($urandom_range(0, 100)) - 50)
                                    : {16'h0, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255))};
        endcase
        cfg_write(a, d);
      end
      rdy_rand = 1;
      for (int r = 0; r < 8; r++) begin
        if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        if ($urandom_range(0, 1) == 0)
          send_row({$urandom, $urandom, $urandom, $urandom});
        else
          send_row(pack(int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 600)) - 300,
                        int'($urandom_range(0, 600)) - 300, int'($urandom_range(0, 600)) - 300));
      end
    end
    drain();
    chk("rand_row_count", 32'(row_count), 32'(n_out));
    chk("rand_busy_idle", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
